// File: rtl/data_mem_responder.sv
// Data-memory responder for MEM-stage loads/stores: one request in flight, byte-enable writes, error flagging.
// Latency: response cycle begins LATENCY edges after the acceptance edge; one-cycle resp_valid strobe.
// Backpressure: req_ready only in IDLE; requests presented while busy are ignored, not queued.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_byte_en,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        hold_write;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_be;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  eff_write;
    logic [31:0]           eff_addr;
    logic [31:0]           eff_wdata;
    logic [3:0]            eff_be;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           wmask;
    logic [31:0]           merged;
    logic                  mem_we;

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);

    // With LATENCY=0 the RESP-entry edge is the acceptance edge, so the live inputs are used there.
    assign eff_write = (state == IDLE) ? req_write   : hold_write;
    assign eff_addr  = (state == IDLE) ? req_addr    : hold_addr;
    assign eff_wdata = (state == IDLE) ? req_wdata   : hold_wdata;
    assign eff_be    = (state == IDLE) ? req_byte_en : hold_be;

    assign addr_err = (eff_addr[1:0] != 2'b00) || (eff_addr[31:ADDR_WIDTH+2] != '0);
    assign word_idx = eff_addr[ADDR_WIDTH+1:2];
    assign wmask    = {{8{eff_be[3]}}, {8{eff_be[2]}}, {8{eff_be[1]}}, {8{eff_be[0]}}};
    assign merged   = (mem[word_idx] & ~wmask) | (eff_wdata & wmask);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP);
    assign mem_we     = enter_resp && eff_write && !addr_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            hold_write <= 1'b0;
            hold_addr  <= 32'd0;
            hold_wdata <= 32'd0;
            hold_be    <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                hold_write <= req_write;
                hold_addr  <= req_addr;
                hold_wdata <= req_wdata;
                hold_be    <= req_byte_en;
            end
        end
    end

    // Response registers are loaded only on RESP entry and cleared on every other edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= addr_err;
            rdata_q <= (addr_err || eff_write) ? 32'd0 : mem[word_idx];
        end else begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[word_idx] <= merged;
    end

    assign resp_valid = (state == RESP);
    assign resp_error = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;

endmodule
